// File: rtl/tia_h_pkg.sv
// Shared horizontal-timing constants and types for the TIA line sequencer.
package tia_h_pkg;

    // Line is 57 counts of 4 color clocks each (228 clocks).
    localparam int unsigned H_COUNT_MAX = 56;
    localparam int unsigned SHS         = 4;   // set hsync
    localparam int unsigned RHS         = 8;   // reset hsync
    localparam int unsigned RHB         = 17;  // reset hblank, normal line
    localparam int unsigned LRHB        = 19;  // reset hblank, hmove-extended line

    typedef logic [5:0] count_t;
    typedef logic [1:0] phase_t;

    // Line counter successor with wrap at the end of the line.
    function automatic count_t next_count(input count_t c);
        return (c == count_t'(H_COUNT_MAX)) ? '0 : c + 6'd1;
    endfunction

endpackage

// File: rtl/tia_h_sequencer_if.sv
// Strobe/status bundle between the CPU-side register decode and the sequencer.
interface tia_h_sequencer_if;
    import tia_h_pkg::*;

    logic   wsync_strobe;
    logic   rsync_strobe;
    logic   hmove_strobe;
    count_t count;
    phase_t phase;
    logic   hsync;
    logic   hblank;
    logic   hmove_blank;
    logic   rdy;
    logic   line_start;

    modport master (
        output wsync_strobe, rsync_strobe, hmove_strobe,
        input  count, phase, hsync, hblank, hmove_blank, rdy, line_start
    );

    modport slave (
        input  wsync_strobe, rsync_strobe, hmove_strobe,
        output count, phase, hsync, hblank, hmove_blank, rdy, line_start
    );

endinterface

// File: rtl/tia_h_phase.sv
// Divide-by-4 color-clock phase counter; advance marks the last phase of a count.
module tia_h_phase
    import tia_h_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   sync_clear,
    output phase_t phase,
    output logic   advance
);

    // Free-running phase, forced to 0 on a line resync.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (sync_clear) begin
            phase <= '0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    assign advance = (phase == 2'd3);

endmodule

// File: rtl/tia_h_sequencer.sv
// Horizontal line sequencer: line counter, sync/blank decodes, WSYNC halt, RSYNC.
module tia_h_sequencer
    import tia_h_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    tia_h_sequencer_if.slave  bus
);

    logic   sync;
    logic   advance;
    logic   primed_q;
    phase_t phase;
    count_t count_q;
    count_t count_d;
    logic   hsync_q;
    logic   hblank_q;
    logic   hmove_blank_q;
    logic   rdy_q;
    logic   line_start_q;
    logic   enter_0;
    logic   enter_shs;
    logic   enter_rhs;
    logic   enter_rhb;
    logic   enter_lrhb;

    // The first edge after reset behaves like RSYNC so line_start marks the restart.
    assign sync = bus.rsync_strobe | ~primed_q;

    tia_h_phase u_phase (
        .clock      (clock),
        .reset      (reset),
        .sync_clear (sync),
        .phase      (phase),
        .advance    (advance)
    );

    assign count_d = advance ? next_count(count_q) : count_q;

    // Decode the edge on which the counter enters each timing point.
    always_comb begin
        enter_0    = advance && (count_d == '0);
        enter_shs  = advance && (count_d == count_t'(SHS));
        enter_rhs  = advance && (count_d == count_t'(RHS));
        enter_rhb  = advance && (count_d == count_t'(RHB));
        enter_lrhb = advance && (count_d == count_t'(LRHB));
    end

    // Counter and all registered line outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            primed_q      <= 1'b0;
            count_q       <= '0;
            hsync_q       <= 1'b0;
            hblank_q      <= 1'b1;
            hmove_blank_q <= 1'b0;
            rdy_q         <= 1'b1;
            line_start_q  <= 1'b0;
        end else if (sync) begin
            primed_q      <= 1'b1;
            count_q       <= '0;
            hsync_q       <= 1'b0;
            hblank_q      <= 1'b1;
            hmove_blank_q <= hmove_blank_q | bus.hmove_strobe;
            // A coincident WSYNC still halts until the following line.
            rdy_q         <= ~bus.wsync_strobe;
            line_start_q  <= 1'b1;
        end else begin
            count_q      <= count_d;
            line_start_q <= enter_0;

            if (enter_shs) begin
                hsync_q <= 1'b1;
            end else if (enter_rhs) begin
                hsync_q <= 1'b0;
            end

            if (enter_0) begin
                hblank_q <= 1'b1;
            end else if (enter_rhb && !hmove_blank_q) begin
                hblank_q <= 1'b0;
            end else if (enter_lrhb && hmove_blank_q) begin
                hblank_q <= 1'b0;
            end

            // A late HMOVE stays latched and extends the next line's blank instead.
            if (bus.hmove_strobe) begin
                hmove_blank_q <= 1'b1;
            end else if (enter_lrhb && hmove_blank_q) begin
                hmove_blank_q <= 1'b0;
            end

            if (bus.wsync_strobe) begin
                rdy_q <= 1'b0;
            end else if (enter_0) begin
                rdy_q <= 1'b1;
            end
        end
    end

    assign bus.count       = count_q;
    assign bus.phase       = phase;
    assign bus.hsync       = hsync_q;
    assign bus.hblank      = hblank_q;
    assign bus.hmove_blank = hmove_blank_q;
    assign bus.rdy         = rdy_q;
    assign bus.line_start  = line_start_q;

endmodule
